// File: rtl/sync_flag_decoder.sv
// Multi-channel sync-word flag decoder: per-channel OFF/PEND/ON FSM with optional confirmation
// depth and refresh watchdog. Define SYNC_FLAG_ERR_CNT_EN to count unrecognised words.
module sync_flag_decoder #(
   parameter real                              TCQ         = 0.1,
   parameter int                               DATA_WIDTH  = 16,
   parameter int                               NUM_FLAGS   = 3,
   parameter logic [NUM_FLAGS*DATA_WIDTH-1:0]  SET_CODES   = {16'h5A53, 16'h5A51, 16'hACC1},
   parameter logic [NUM_FLAGS*DATA_WIDTH-1:0]  CLR_CODES   = {16'h5A51, 16'h5A50, 16'hACC0},
   parameter int                               CONFIRM_CNT = 0,
   parameter int                               TIMEOUT_CYC = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  rx_valid_i,
   input  logic [DATA_WIDTH-1:0] rx_data_i,
   output logic [NUM_FLAGS-1:0]  flag_o,
   output logic [NUM_FLAGS-1:0]  flag_rise_o,
   output logic [NUM_FLAGS-1:0]  flag_fall_o,
   output logic [NUM_FLAGS-1:0]  timeout_o,
   input  logic                  timeout_clr_i,
   output logic [15:0]           err_cnt_o
);

   localparam int CW = (CONFIRM_CNT > 0) ? $clog2(CONFIRM_CNT + 1) : 1;
   localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

   // TCQ is accepted for compatibility with older benches; registers here are zero-delay.
   if (TCQ < 0.0 || NUM_FLAGS < 1 || NUM_FLAGS > 16) begin : g_bad_param
      $error("sync_flag_decoder: illegal TCQ or NUM_FLAGS");
   end

   typedef enum logic [1:0] {ST_OFF, ST_PEND, ST_ON} state_t;

   state_t               state_q [NUM_FLAGS];
   logic [CW-1:0]        cnt_q   [NUM_FLAGS];
   logic [TW-1:0]        tmo_q   [NUM_FLAGS];
   logic [NUM_FLAGS-1:0] set_hit;
   logic [NUM_FLAGS-1:0] clr_hit;

   always_comb begin
      set_hit = '0;
      clr_hit = '0;
      for (int i = 0; i < NUM_FLAGS; i++) begin
         set_hit[i] = rx_valid_i && (rx_data_i == SET_CODES[i*DATA_WIDTH +: DATA_WIDTH]);
         clr_hit[i] = rx_valid_i && (rx_data_i == CLR_CODES[i*DATA_WIDTH +: DATA_WIDTH]);
      end
   end

   // Clear outranks set everywhere, so a channel whose set and clear codes coincide never asserts.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < NUM_FLAGS; i++) begin
            state_q[i] <= ST_OFF;
            cnt_q[i]   <= '0;
            tmo_q[i]   <= '0;
         end
         flag_o      <= '0;
         flag_rise_o <= '0;
         flag_fall_o <= '0;
         timeout_o   <= '0;
      end else begin
         flag_rise_o <= '0;
         flag_fall_o <= '0;
         if (timeout_clr_i) timeout_o <= '0;
         for (int i = 0; i < NUM_FLAGS; i++) begin
            case (state_q[i])
               ST_OFF: begin
                  if (set_hit[i] && !clr_hit[i]) begin
                     if (CONFIRM_CNT == 0) begin
                        state_q[i]     <= ST_ON;
                        tmo_q[i]       <= '0;
                        flag_o[i]      <= 1'b1;
                        flag_rise_o[i] <= 1'b1;
                     end else begin
                        state_q[i] <= ST_PEND;
                        cnt_q[i]   <= CW'(1);
                     end
                  end
               end
               ST_PEND: begin
                  if (clr_hit[i]) begin
                     state_q[i] <= ST_OFF;
                     cnt_q[i]   <= '0;
                  end else if (set_hit[i]) begin
                     if (cnt_q[i] == CW'(CONFIRM_CNT)) begin
                        state_q[i]     <= ST_ON;
                        cnt_q[i]       <= '0;
                        tmo_q[i]       <= '0;
                        flag_o[i]      <= 1'b1;
                        flag_rise_o[i] <= 1'b1;
                     end else begin
                        cnt_q[i] <= cnt_q[i] + CW'(1);
                     end
                  end else if (rx_valid_i) begin
                     state_q[i] <= ST_OFF;
                     cnt_q[i]   <= '0;
                  end
               end
               ST_ON: begin
                  if (clr_hit[i]) begin
                     state_q[i]     <= ST_OFF;
                     tmo_q[i]       <= '0;
                     flag_o[i]      <= 1'b0;
                     flag_fall_o[i] <= 1'b1;
                  end else if (set_hit[i]) begin
                     tmo_q[i] <= '0;
                  end else if (TIMEOUT_CYC != 0) begin
                     // A word arriving in the expiry cycle is handled above and pre-empts the timeout.
                     if (tmo_q[i] == TW'(TIMEOUT_CYC)) begin
                        state_q[i]     <= ST_OFF;
                        tmo_q[i]       <= '0;
                        flag_o[i]      <= 1'b0;
                        flag_fall_o[i] <= 1'b1;
                        timeout_o[i]   <= 1'b1;
                     end else begin
                        tmo_q[i] <= tmo_q[i] + TW'(1);
                     end
                  end
               end
               default: begin
                  state_q[i] <= ST_OFF;
                  cnt_q[i]   <= '0;
                  tmo_q[i]   <= '0;
                  flag_o[i]  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef SYNC_FLAG_ERR_CNT_EN
   // Saturating count of valid words that match no set or clear code on any channel.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         err_cnt_o <= 16'h0000;
      end else if (rx_valid_i && !(|(set_hit | clr_hit)) && (err_cnt_o != 16'hFFFF)) begin
         err_cnt_o <= err_cnt_o + 16'h0001;
      end
   end
`else
   assign err_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_sync_flag_decoder.sv
// Bench for sync_flag_decoder: a default-parameter instance and a confirm/watchdog/shared-code
// instance share one word stream and are compared every cycle against a rule-level model.
module tb_sync_flag_decoder;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        rx_valid;
   logic [15:0] rx_data;
   logic        tclr;

   logic [2:0]  a_flag, a_rise, a_fall, a_to;
   logic [15:0] a_err;
   logic [1:0]  b_flag, b_rise, b_fall, b_to;
   logic [15:0] b_err;

   localparam logic [31:0] B_SET = {16'h1111, 16'hACC1};
   localparam logic [31:0] B_CLR = {16'h1111, 16'hACC0};
   localparam int          B_CFM = 2;
   localparam int          B_TMO = 100;

   sync_flag_decoder dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
      .flag_o(a_flag), .flag_rise_o(a_rise), .flag_fall_o(a_fall), .timeout_o(a_to),
      .timeout_clr_i(tclr), .err_cnt_o(a_err)
   );

   sync_flag_decoder #(
      .NUM_FLAGS(2), .SET_CODES(B_SET), .CLR_CODES(B_CLR),
      .CONFIRM_CNT(B_CFM), .TIMEOUT_CYC(B_TMO)
   ) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
      .flag_o(b_flag), .flag_rise_o(b_rise), .flag_fall_o(b_fall), .timeout_o(b_to),
      .timeout_clr_i(tclr), .err_cnt_o(b_err)
   );

   // ---------------- reference model ----------------
   logic [15:0] a_sc [3] = '{16'hACC1, 16'h5A51, 16'h5A53};
   logic [15:0] a_cc [3] = '{16'hACC0, 16'h5A50, 16'h5A51};
   logic [15:0] b_sc [2] = '{16'hACC1, 16'h1111};
   logic [15:0] b_cc [2] = '{16'hACC0, 16'h1111};

   logic [2:0] a_on, a_exp_rise, a_exp_fall, a_exp_to;
   int         a_streak [3];
   int         a_age    [3];
   int         a_exp_err;
   logic [1:0] b_on, b_exp_rise, b_exp_fall, b_exp_to;
   int         b_streak [2];
   int         b_age    [2];
   int         b_exp_err;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One channel, one cycle: streak = consecutive set words seen while off, age = idle cycles while on.
   task automatic chan_step(input bit v, input logic [15:0] d, input logic [15:0] sc, input logic [15:0] cc,
                            input int cfm, input int tmo, input bit on_i, input int streak_i, input int age_i,
                            output bit on_o, output int streak_o, output int age_o, output bit to_ev);
      on_o = on_i; streak_o = streak_i; age_o = age_i; to_ev = 1'b0;
      if (v && d == cc) begin
         on_o = 1'b0; streak_o = 0;
      end else if (v && d == sc) begin
         if (on_o) age_o = 0;
         else begin
            streak_o++;
            if (streak_o > cfm) begin on_o = 1'b1; age_o = 0; streak_o = 0; end
         end
      end else begin
         if (v) streak_o = 0;
         if (on_o && tmo > 0) begin
            if (age_o == tmo) begin on_o = 1'b0; to_ev = 1'b1; end
            else age_o++;
         end
      end
   endtask

   task automatic model_reset();
      a_on = '0; a_exp_rise = '0; a_exp_fall = '0; a_exp_to = '0; a_exp_err = 0;
      b_on = '0; b_exp_rise = '0; b_exp_fall = '0; b_exp_to = '0; b_exp_err = 0;
      for (int i = 0; i < 3; i++) begin a_streak[i] = 0; a_age[i] = 0; end
      for (int i = 0; i < 2; i++) begin b_streak[i] = 0; b_age[i] = 0; end
   endtask

   task automatic model_tick(input bit v, input logic [15:0] d, input bit tc);
      logic [2:0] a_prev;
      logic [1:0] b_prev;
      bit on_n, te, any;
      int s_n, g_n;
      a_prev = a_on;
      b_prev = b_on;
      if (tc) begin a_exp_to = '0; b_exp_to = '0; end
      any = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chan_step(v, d, a_sc[i], a_cc[i], 0, 0, a_on[i], a_streak[i], a_age[i], on_n, s_n, g_n, te);
         a_on[i] = on_n; a_streak[i] = s_n; a_age[i] = g_n;
         if (te) a_exp_to[i] = 1'b1;
         if (v && (d == a_sc[i] || d == a_cc[i])) any = 1'b1;
      end
`ifdef SYNC_FLAG_ERR_CNT_EN
      if (v && !any && a_exp_err < 65535) a_exp_err++;
`endif
      any = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chan_step(v, d, b_sc[i], b_cc[i], B_CFM, B_TMO, b_on[i], b_streak[i], b_age[i], on_n, s_n, g_n, te);
         b_on[i] = on_n; b_streak[i] = s_n; b_age[i] = g_n;
         if (te) b_exp_to[i] = 1'b1;
         if (v && (d == b_sc[i] || d == b_cc[i])) any = 1'b1;
      end
`ifdef SYNC_FLAG_ERR_CNT_EN
      if (v && !any && b_exp_err < 65535) b_exp_err++;
`endif
      a_exp_rise = a_on & ~a_prev;  a_exp_fall = ~a_on & a_prev;
      b_exp_rise = b_on & ~b_prev;  b_exp_fall = ~b_on & b_prev;
   endtask

   // ---------------- scoreboard compare ----------------
   task automatic compare_all();
      check("a_flag", a_flag, a_on);
      check("a_rise", a_rise, a_exp_rise);
      check("a_fall", a_fall, a_exp_fall);
      check("a_timeout", a_to, a_exp_to);
      check("a_err", a_err, a_exp_err);
      check("b_flag", b_flag, b_on);
      check("b_rise", b_rise, b_exp_rise);
      check("b_fall", b_fall, b_exp_fall);
      check("b_timeout", b_to, b_exp_to);
      check("b_err", b_err, b_exp_err);
   endtask

   // ---------------- driver ----------------
   task automatic step(input bit v, input logic [15:0] d, input bit tc);
      @(negedge clk);
      rx_valid = v;
      rx_data  = v ? d : 16'($urandom);
      tclr     = tc;
      @(posedge clk);
      model_tick(v, rx_data, tc);
      #1 compare_all();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 16'h0000, 1'b0);
   endtask

   function automatic logic [15:0] pick_word();
      case ($urandom_range(0, 9))
         0, 1:    return 16'hACC1;
         2:       return 16'hACC0;
         3:       return 16'h5A51;
         4:       return 16'h5A50;
         5:       return 16'h5A53;
         6:       return 16'h1111;
         7:       return 16'hDEAD;
         default: return 16'($urandom);
      endcase
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      logic [15:0] exp_err5;
      rst_n = 1'b0; rx_valid = 1'b0; rx_data = 16'h0000; tclr = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      rst_n = 1'b1;

      // set/clear on flag 0, then cross-channel interaction on flags 1 and 2
      step(1'b1, 16'hACC1, 1'b0);
      check("a_set0_flag", a_flag[0], 1'b1);
      check("a_set0_rise", a_rise[0], 1'b1);
      idle(1);
      check("a_rise0_once", a_rise[0], 1'b0);
      step(1'b1, 16'hACC0, 1'b0);
      check("a_clr0_flag", a_flag[0], 1'b0);
      check("a_clr0_fall", a_fall[0], 1'b1);
      step(1'b1, 16'h5A51, 1'b0);
      step(1'b1, 16'h5A53, 1'b0);
      step(1'b1, 16'h5A50, 1'b0);
      check("a_only_flag2", a_flag, 3'b100);
      step(1'b1, 16'h5A51, 1'b0);
      check("a_5a51_clears2", a_flag, 3'b010);

      // confirmation depth 2: an interposed word restarts the count
      step(1'b1, 16'hACC1, 1'b0);
      step(1'b1, 16'h1234, 1'b0);
      step(1'b1, 16'hACC1, 1'b0);
      step(1'b1, 16'hACC1, 1'b0);
      check("b_cfm_not_yet", b_flag[0], 1'b0);
      step(1'b1, 16'hACC1, 1'b0);
      check("b_cfm_third", b_flag[0], 1'b1);
      check("b_cfm_rise", b_rise[0], 1'b1);
      step(1'b1, 16'hACC1, 1'b0);
      check("b_cfm_fourth", b_flag[0], 1'b1);

      // watchdog: refresh at cycle 90 keeps it alive past 150, then let it expire
      idle(89);
      step(1'b1, 16'hACC1, 1'b0);
      idle(60);
      check("b_alive_150", b_flag[0], 1'b1);
      idle(45);
      check("b_expired", b_flag[0], 1'b0);
      check("b_to_set", b_to[0], 1'b1);
      idle(5);
      check("b_to_held", b_to[0], 1'b1);
      step(1'b0, 16'h0000, 1'b1);
      check("b_to_cleared", b_to[0], 1'b0);

      // identical set and clear code: clear wins
      step(1'b1, 16'h1111, 1'b0);
      check("b_same_code", b_flag[1], 1'b0);

      // unrecognised words
      for (int k = 0; k < 5; k++) step(1'b1, 16'hDEAD, 1'b0);
`ifdef SYNC_FLAG_ERR_CNT_EN
      exp_err5 = 16'd5 + 16'(a_exp_err - 5);
`else
      exp_err5 = 16'd0;
`endif
      check("a_err_dead", a_err, exp_err5);

      // reset in the middle of a confirmation
      step(1'b1, 16'hACC0, 1'b0);
      step(1'b1, 16'hACC1, 1'b0);
      @(negedge clk);
      rst_n = 1'b0; rx_valid = 1'b0; tclr = 1'b0;
      #1;
      check("rst_a_flag", a_flag, 3'b000);
      check("rst_a_rise", a_rise, 3'b000);
      check("rst_b_all", {b_flag, b_rise, b_fall, b_to}, 8'h00);
      check("rst_err", {a_err, b_err}, 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 16'hACC1, 1'b0);
      step(1'b1, 16'hACC1, 1'b0);
      check("b_pend_discarded", b_flag[0], 1'b0);

      // randomized traffic with occasional long silences for the watchdog
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 99) == 0) idle(110);
         step($urandom_range(0, 3) != 0, pick_word(), $urandom_range(0, 19) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
